// File: rtl/snn_cmd_sequencer.sv
// Sole master of the broadcast neuron command bus: drains queued host config writes,
// then runs an optional CLEAR followed by a programmed number of tick cycles.
module snn_cmd_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int CMD_WIDTH  = 8,
    parameter int INT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TICK_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [ADDR_WIDTH-1:0]  cfg_addr,
    input  logic [CMD_WIDTH-1:0]   cfg_cmd,
    input  logic [2*INT_WIDTH-1:0] cfg_arg,
    output logic                   cfg_error,
    input  logic                   run_start,
    input  logic [TICK_WIDTH-1:0]  run_ticks,
    input  logic                   run_clear,
    output logic                   busy,
    output logic                   done,
    output logic [TICK_WIDTH-1:0]  tick_count,
    output logic [ADDR_WIDTH-1:0]  bus_addr,
    output logic [CMD_WIDTH-1:0]   bus_cmd,
    output logic [2*INT_WIDTH-1:0] bus_arg
);
    localparam int ARG_WIDTH = 2 * INT_WIDTH;
    localparam int ENTRY_W   = ADDR_WIDTH + CMD_WIDTH + ARG_WIDTH;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam logic [CMD_WIDTH-1:0] CMD_NOP   = '1;
    localparam logic [CMD_WIDTH-1:0] CMD_CLEAR = {{(CMD_WIDTH-2){1'b1}}, 2'b01};

    typedef enum logic [2:0] {S_IDLE, S_CFG, S_CLEAR, S_RUN, S_DONE} state_t;

    state_t                  state_reg, state_next;
    logic [ENTRY_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0]      head_entry;
    logic [PTR_W-1:0]        wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]        count_reg, count_next;
    logic                    ready_reg, ready_next;
    logic                    error_reg, error_next;
    logic                    pending_reg, pending_next;
    logic [TICK_WIDTH-1:0]   ticks_reg, ticks_next;
    logic                    clear_reg, clear_next;
    logic [TICK_WIDTH-1:0]   tick_reg, tick_next;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;
    logic [ADDR_WIDTH-1:0]   bus_addr_reg, bus_addr_next;
    logic [CMD_WIDTH-1:0]    bus_cmd_reg, bus_cmd_next;
    logic [ARG_WIDTH-1:0]    bus_arg_reg, bus_arg_next;
    logic                    accept, push, pop, start_ok, fifo_empty;

    assign accept     = cfg_valid && ready_reg;
    assign push       = accept && (cfg_cmd != '0);
    assign fifo_empty = (count_reg == '0);
    assign head_entry = fifo_mem[rd_ptr_reg];
    // A new run is only taken while no run is pending or executing.
    assign start_ok   = run_start && !pending_reg && (state_reg == S_IDLE || state_reg == S_CFG);

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {cfg_addr, cfg_cmd, cfg_arg};
    end

    always_comb begin
        state_next    = state_reg;
        pop           = 1'b0;
        pending_next  = pending_reg;
        ticks_next    = ticks_reg;
        clear_next    = clear_reg;
        tick_next     = tick_reg;
        done_next     = 1'b0;
        error_next    = accept && (cfg_cmd == '0);
        bus_addr_next = '0;
        bus_cmd_next  = CMD_NOP;
        bus_arg_next  = '0;

        if (start_ok) begin
            pending_next = 1'b1;
            ticks_next   = run_ticks;
            clear_next   = run_clear;
            tick_next    = '0;
        end

        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_next = S_CFG;
                end else if (pending_reg) begin
                    pending_next = 1'b0;
                    if (clear_reg)
                        state_next = S_CLEAR;
                    else if (ticks_reg == '0)
                        state_next = S_DONE;
                    else
                        state_next = S_RUN;
                end
            end
            S_CFG: begin
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    bus_addr_next = head_entry[ENTRY_W-1 -: ADDR_WIDTH];
                    bus_cmd_next  = head_entry[ARG_WIDTH +: CMD_WIDTH];
                    bus_arg_next  = head_entry[ARG_WIDTH-1:0];
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_CLEAR: begin
                bus_cmd_next = CMD_CLEAR;
                state_next   = (ticks_reg == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                bus_cmd_next = '0;
                tick_next    = tick_reg + TICK_WIDTH'(1);
                if (tick_next == ticks_reg)
                    state_next = S_DONE;
            end
            S_DONE: begin
                done_next  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        wr_ptr_next = wr_ptr_reg + PTR_W'(push);
        rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
        count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
        // Ready is recomputed from the post-edge count, so a pop at full frees space one cycle later.
        ready_next  = (count_next != CNT_W'(FIFO_DEPTH));
        busy_next   = (state_next != S_IDLE) || pending_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            ready_reg    <= 1'b0;
            error_reg    <= 1'b0;
            pending_reg  <= 1'b0;
            ticks_reg    <= '0;
            clear_reg    <= 1'b0;
            tick_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            bus_addr_reg <= '0;
            bus_cmd_reg  <= CMD_NOP;
            bus_arg_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            ready_reg    <= ready_next;
            error_reg    <= error_next;
            pending_reg  <= pending_next;
            ticks_reg    <= ticks_next;
            clear_reg    <= clear_next;
            tick_reg     <= tick_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            bus_addr_reg <= bus_addr_next;
            bus_cmd_reg  <= bus_cmd_next;
            bus_arg_reg  <= bus_arg_next;
        end
    end

    assign cfg_ready  = ready_reg;
    assign cfg_error  = error_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign tick_count = tick_reg;
    assign bus_addr   = bus_addr_reg;
    assign bus_cmd    = bus_cmd_reg;
    assign bus_arg    = bus_arg_reg;
endmodule

// File: tb/tb_snn_cmd_sequencer.sv
// Scoreboard bench for snn_cmd_sequencer: stimulus queues expected bus words and done
// events; a negedge monitor checks every non-NOP bus word and every done pulse in order.
module tb_snn_cmd_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [7:0]  cfg_addr = '0;
    logic [7:0]  cfg_cmd = '0;
    logic [15:0] cfg_arg = '0;
    logic        run_start = 1'b0;
    logic [15:0] run_ticks = '0;
    logic        run_clear = 1'b0;
    logic        cfg_ready, cfg_error, busy, done;
    logic [15:0] tick_count;
    logic [7:0]  bus_addr, bus_cmd;
    logic [15:0] bus_arg;

    typedef struct {
        int          kind;   // 0 = bus word, 1 = done pulse
        logic [7:0]  addr;
        logic [7:0]  cmd;
        logic [15:0] arg;
        logic [15:0] ticks;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    snn_cmd_sequencer dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
        .cfg_cmd(cfg_cmd), .cfg_arg(cfg_arg), .cfg_error(cfg_error),
        .run_start(run_start), .run_ticks(run_ticks), .run_clear(run_clear),
        .busy(busy), .done(done), .tick_count(tick_count),
        .bus_addr(bus_addr), .bus_cmd(bus_cmd), .bus_arg(bus_arg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic exp_bus(input logic [7:0] a, input logic [7:0] c, input logic [15:0] g);
        exp_t e;
        e.kind = 0; e.addr = a; e.cmd = c; e.arg = g; e.ticks = '0;
        exp_q.push_back(e);
    endtask

    task automatic exp_done(input logic [15:0] t);
        exp_t e;
        e.kind = 1; e.addr = '0; e.cmd = '0; e.arg = '0; e.ticks = t;
        exp_q.push_back(e);
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [7:0] a, input logic [7:0] c, input logic [15:0] g);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        cfg_valid = 1'b1; cfg_addr = a; cfg_cmd = c; cfg_arg = g;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = cfg_ready;
            @(posedge clk);
            n++;
        end
        #1 cfg_valid = 1'b0;
        if (!acc) chk("send_accept", {31'd0, acc}, 32'd1);
        if (acc && c != 8'd0) exp_bus(a, c, g);
    endtask

    task automatic start_run(input logic [15:0] t, input logic c);
        run_ticks = t; run_clear = c; run_start = 1'b1;
        @(posedge clk);
        #1 run_start = 1'b0;
        if (c) exp_bus(8'd0, 8'd253, 16'd0);
        for (int i = 0; i < int'(t); i++) exp_bus(8'd0, 8'd0, 16'd0);
        exp_done(t);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, exp_q.size(), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_cmd != 8'hFF) begin
                if (exp_q.size() == 0 || exp_q[0].kind != 0) begin
                    chk("unexpected_bus_word", {8'd0, bus_addr, bus_cmd, 8'd0}, {16'd0, 8'hFF, 8'd0});
                end else begin
                    chk("bus_word", {bus_addr, bus_cmd, bus_arg},
                        {exp_q[0].addr, exp_q[0].cmd, exp_q[0].arg});
                    void'(exp_q.pop_front());
                end
            end
            if (done) begin
                if (exp_q.size() == 0 || exp_q[0].kind != 1) begin
                    chk("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    chk("done_tick_count", {16'd0, tick_count}, {16'd0, exp_q[0].ticks});
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_bus_cmd", {24'd0, bus_cmd}, 32'd255);
        chk("rst_bus_addr_arg", {8'd0, bus_addr, bus_arg}, 32'd0);
        chk("rst_flags", {28'd0, done, cfg_error, busy, cfg_ready}, 32'd0);
        chk("rst_tick_count", {16'd0, tick_count}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", {31'd0, cfg_ready}, 32'd1);

        // Three back-to-back config entries
        send(8'd5, 8'd1, 16'h0080);
        send(8'd5, 8'd2, 16'h0040);
        send(8'd7, 8'd4, 16'hFFF0);
        wait_drain("cfg3_drain");
        idle_cycles(2);
        chk("cfg3_busy_low", {31'd0, busy}, 32'd0);

        // CLEAR then 10 ticks
        start_run(16'd10, 1'b1);
        chk("run10_busy", {31'd0, busy}, 32'd1);
        wait_drain("run10_drain");
        idle_cycles(2);
        chk("run10_tick_hold", {16'd0, tick_count}, 32'd10);

        // Six entries offered during a 20-tick run
        start_run(16'd20, 1'b0);
        idle_cycles(2);
        for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 8'(8'd1 + i), 16'(16'h0100 * (i + 1)));
        @(negedge clk);
        chk("fifo_full_ready", {31'd0, cfg_ready}, 32'd0);
        @(posedge clk); #1;
        send(8'h14, 8'd5, 16'h0500);
        send(8'h15, 8'd6, 16'h0600);
        wait_drain("full_drain");

        // Zero-tick run behind two queued entries
        idle_cycles(2);
        send(8'h30, 8'd9, 16'h1111);
        send(8'h31, 8'd10, 16'h2222);
        start_run(16'd0, 1'b0);
        wait_drain("zero_run_drain");
        chk("zero_run_tick", {16'd0, tick_count}, 32'd0);

        // Single-entry latency: on the bus in the cycle after edge N+2
        idle_cycles(2);
        send(8'h21, 8'd3, 16'h1234);
        @(negedge clk);
        chk("lat_cycle1_nop", {24'd0, bus_cmd}, 32'd255);
        @(negedge clk);
        chk("lat_cycle2_nop", {24'd0, bus_cmd}, 32'd255);
        @(negedge clk);
        chk("lat_cycle3_entry", {24'd0, bus_cmd}, 32'd3);
        @(posedge clk); #1;
        wait_drain("lat_drain");

        // Zero command is dropped with an error pulse
        idle_cycles(2);
        send(8'd9, 8'd0, 16'h0055);
        @(negedge clk);
        chk("zero_cmd_error", {31'd0, cfg_error}, 32'd1);
        chk("zero_cmd_ready", {31'd0, cfg_ready}, 32'd1);
        @(negedge clk);
        chk("zero_cmd_error_clear", {31'd0, cfg_error}, 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of a 20-tick run
        run_ticks = 16'd20; run_clear = 1'b0; run_start = 1'b1;
        @(posedge clk);
        #1 run_start = 1'b0;
        for (int i = 0; i < 5; i++) exp_bus(8'd0, 8'd0, 16'd0);
        wait_drain("pre_rst_ticks");
        rst = 1'b1;
        #1;
        chk("midrun_rst_bus_cmd", {24'd0, bus_cmd}, 32'd255);
        chk("midrun_rst_tick", {16'd0, tick_count}, 32'd0);
        chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'd0, cfg_ready}, 32'd1);
        start_run(16'd3, 1'b0);
        wait_drain("post_rst_run3");
        idle_cycles(4);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/snn_cmd_sequencer.md
Name: snn_cmd_sequencer

Overview:
- Single master of the shared neuron command bus (addr/cmd/cmd_arg) broadcast to every spiking neuron in the fabric.
- Queues host configuration writes (weights, bias, delivery time) and serialises them onto the bus, one per cycle.
- Issues an optional broadcast CLEAR, then a programmed number of simulation ticks (cmd = 0).
- Arbitrates so that config writes and run ticks never overlap; config always wins.

Parameters:
- ADDR_WIDTH, 8, neuron address width.
- CMD_WIDTH, 8, command width; CMD_CLEAR = 2^CMD_WIDTH-3; CMD_NOP = 2^CMD_WIDTH-1.
- INT_WIDTH, 8, neuron integer width; cmd_arg width = 2*INT_WIDTH.
- FIFO_DEPTH, 4, config queue entries (power of two, >= 2).
- TICK_WIDTH, 16, width of run length and tick counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cfg_valid  in  1  host config entry valid
- cfg_ready  out  1  queue can accept an entry
- cfg_addr  in  ADDR_WIDTH  target neuron
- cfg_cmd  in  CMD_WIDTH  neuron command (must be non-zero)
- cfg_arg  in  2*INT_WIDTH  command argument
- cfg_error  out  1  one-cycle pulse: entry with cfg_cmd==0 was dropped
- run_start  in  1  request a run (single-cycle pulse)
- run_ticks  in  TICK_WIDTH  number of tick cycles, sampled with run_start
- run_clear  in  1  issue CLEAR before ticks, sampled with run_start
- busy  out  1  high whenever not in IDLE or a run is pending
- done  out  1  one-cycle pulse at end of run
- tick_count  out  TICK_WIDTH  ticks issued in current/last run
- bus_addr  out  ADDR_WIDTH  neuron bus address
- bus_cmd  out  CMD_WIDTH  neuron bus command
- bus_arg  out  2*INT_WIDTH  neuron bus argument

Behaviour:
- All outputs registered.
- Reset (async, any time, including mid-run):
  - FIFO emptied; pending run dropped; state IDLE.
  - bus_cmd=CMD_NOP, bus_addr=0, bus_arg=0.
  - done=0, cfg_error=0, tick_count=0, busy=0.
  - cfg_ready=1 from the first edge after rst deasserts.
- Idle bus value is always CMD_NOP: neurons ignore it. bus_cmd must never be 0 outside RUN.
- Handshake and FIFO:
  - Entry accepted on a rising edge with cfg_valid && cfg_ready.
  - cfg_ready = !full, registered, no combinational path from cfg_valid.
  - At full, cfg_ready=0; a simultaneous pop does not make room in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Entry with cfg_cmd==0: handshake completes, entry not stored, cfg_error pulses on the next cycle.
- States:
  - IDLE: if FIFO non-empty -> CFG. Else if a run is pending -> CLEAR (if clear flag set) or RUN.
  - CFG: each cycle pop one entry and drive bus_addr/cmd/arg for exactly one cycle. When FIFO is empty, drive NOP and return to IDLE. Back-to-back entries may appear on consecutive cycles.
  - CLEAR: one cycle: bus_cmd=CMD_CLEAR, bus_addr=0, bus_arg=0. Then -> RUN.
  - RUN: bus_cmd=0, bus_addr=0, bus_arg=0 for exactly run_ticks consecutive cycles. tick_count increments per tick cycle. Then -> DONE.
  - DONE: bus NOP, done=1 for one cycle -> IDLE.
- Latency:
  - An entry accepted at edge N with an empty FIFO in IDLE is on the bus for the cycle following edge N+2.
  - A run_start at edge N in IDLE with an empty FIFO puts CLEAR/first tick on the bus after edge N+2.
- Run request:
  - run_start latches run_ticks/run_clear into a pending slot; tick_count clears to 0 at latch time.
  - A run_start while a run is pending or in CLEAR/RUN/DONE is ignored.
  - Config priority: a pending run waits until the FIFO is empty, including entries accepted while pending.
  - Entries accepted during CLEAR/RUN are queued and issued only after DONE.
  - run_ticks==0: optional CLEAR, then DONE directly; no tick cycles.
  - Simultaneous cfg accept and run_start in IDLE: the entry is issued before the run.
- tick_count holds its final value until the next accepted run_start or reset.

Test Plan:
- Reset then 3 entries (addr 5, cmd 1, arg 0x0080; addr 5, cmd 2, arg 0x0040; addr 7, cmd 4, arg 0xFFF0) -> bus shows them on 3 consecutive cycles in order, then CMD_NOP (255); busy falls afterwards.
- run_start with run_ticks=10, run_clear=1 -> one cycle bus_cmd=253, addr 0; then exactly 10 cycles bus_cmd=0; done pulses once; tick_count=10.
- Hold cfg_valid for 6 entries with FIFO_DEPTH=4 while in RUN -> cfg_ready drops after 4; no entry appears before done. The remaining 2 are accepted after draining starts; all 6 are issued in order.
- run_start with FIFO holding 2 entries, run_ticks=0, run_clear=0 -> 2 config cycles, no tick or CLEAR cycle, done pulse, tick_count=0.
- Entry with cfg_cmd=0 -> cfg_ready stays high, cfg_error pulses once, bus stays NOP.
- Assert rst during tick 5 of a 20-tick run -> bus_cmd=255 immediately, FIFO empty, no done. A new run of 3 ticks afterwards completes normally.
